// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that turns set/reset requests into one-cycle
// pulses on an internal SR flag bank, with a bank-wide clear.
module sr_flag_arbiter #(
    parameter int N_REQ  = 4,
    parameter int N_FLAG = 8,
    parameter int IDX_W  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   clr_all,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       req_op,
    input  logic [N_REQ*IDX_W-1:0] req_idx,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_FLAG-1:0]      sr_s,
    output logic [N_FLAG-1:0]      sr_r,
    output logic [N_FLAG-1:0]      flag_q,
    output logic                   busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        CLEAR = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [N_FLAG-1:0]  sr_s_q, sr_s_d;
    logic [N_FLAG-1:0]  sr_r_q, sr_r_d;
    logic [N_FLAG-1:0]  flag_d;

    logic               grant_ok;
    logic               win_vld;
    logic [PTR_W-1:0]   win;
    logic               sel_op;
    logic [IDX_W-1:0]   sel_idx;

    // State register; reset always lands in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: clear wins over hold, CLEAR lasts one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (clr_all)  state_d = CLEAR;
                else if (!en) state_d = HOLD;
            end
            CLEAR: begin
                state_d = en ? RUN : HOLD;
            end
            HOLD: begin
                if (clr_all) state_d = CLEAR;
                else if (en) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Round-robin search: first active request at or after ptr_q.
    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        for (int o = 0; o < N_REQ; o++) begin
            if (!win_vld && req[(int'(ptr_q) + o) % N_REQ]) begin
                win_vld = 1'b1;
                win     = PTR_W'((int'(ptr_q) + o) % N_REQ);
            end
        end
    end

    // Output logic: grant only in RUN with the block enabled and no clear.
    always_comb begin
        grant_ok = !rst && (state_q == RUN) && en && !clr_all;
        gnt      = '0;
        if (grant_ok && win_vld) begin
            gnt[win] = 1'b1;
        end
        sel_op  = req_op[win];
        sel_idx = req_idx[int'(win)*IDX_W +: IDX_W];
    end

    // Pulse and pointer next-state; out-of-range indices get no pulse.
    always_comb begin
        sr_s_d = '0;
        sr_r_d = '0;
        ptr_d  = ptr_q;
        if (state_d == CLEAR) begin
            sr_r_d = '1;
        end else if (|gnt) begin
            ptr_d = PTR_W'((int'(win) + 1) % N_REQ);
            for (int v = 0; v < N_FLAG; v++) begin
                if (sel_idx == IDX_W'(v)) begin
                    sr_s_d[v] = sel_op;
                    sr_r_d[v] = !sel_op;
                end
            end
        end
    end

    // SR flag semantics; set and reset are never issued together.
    always_comb begin
        flag_d = (flag_q | sr_s_q) & ~sr_r_q;
    end

    // Datapath registers; reset drops any in-flight pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= '0;
            sr_s_q <= '0;
            sr_r_q <= '0;
            flag_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            sr_s_q <= sr_s_d;
            sr_r_q <= sr_r_d;
            flag_q <= flag_d;
        end
    end

    assign sr_s = sr_s_q;
    assign sr_r = sr_r_q;
    assign busy = (state_q == CLEAR) | (|sr_s_q) | (|sr_r_q);

endmodule
